// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALUop/funct encodings, default widths and the
// control-word layout carried down the pipeline.
package cpu_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int REG_W_DEF  = 5;

   typedef enum logic [2:0] {
      ALU_LWSW  = 3'b000,
      ALU_BEQ   = 3'b001,
      ALU_ADDI  = 3'b010,
      ALU_SUBI  = 3'b011,
      ALU_RTYPE = 3'b100
   } alu_op_e;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_XOR = 6'b100110;
   localparam logic [5:0] FUNCT_JR  = 6'b001000;

   typedef struct packed {
      logic [2:0] alu_op;
      logic [5:0] funct;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       reg_dst;
   } ctrl_t;

   // All-zero word: ALUop add, no writeback, no store -- architecturally inert.
   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard check between the load in EX and the instruction in ID.
// Purely combinational so the forwarding unit can share it.
module load_use_detect #(
   parameter int REG_W = 5
) (
   input  logic             ex_valid_i,
   input  logic             ex_mem_read_i,
   input  logic [REG_W-1:0] ex_rt_i,
   input  logic             id_valid_i,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   output logic             hazard_o
);

   // r0 is hardwired to zero, so a load targeting it never produces a dependency.
   assign hazard_o = ex_valid_i & ex_mem_read_i & id_valid_i & (ex_rt_i != '0) &
                     ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion on hazard or
// flush, and a saturating bubble counter for performance debug.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_W  = REG_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [2:0]        id_alu_op,
   input  logic [5:0]        id_funct,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   input  logic              id_alu_src,
   input  logic              id_reg_dst,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   output logic              stall_out,
   output logic              ex_valid,
   output logic [2:0]        ex_alu_op,
   output logic [5:0]        ex_funct,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg,
   output logic              ex_alu_src,
   output logic              ex_reg_dst,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_rt,
   output logic [REG_W-1:0]  ex_rd,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [CNT_W-1:0]  bubble_count
);

   ctrl_t             ctrl_q, ctrl_d;
   logic              valid_q, valid_d;
   logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
   logic [CNT_W-1:0]  bubble_q, bubble_d;
   logic              hazard, load_bubble;

   load_use_detect #(.REG_W(REG_W)) u_lud (
      .ex_valid_i    (valid_q),
      .ex_mem_read_i (ctrl_q.mem_read),
      .ex_rt_i       (rt_q),
      .id_valid_i    (id_valid),
      .id_rs_i       (id_rs),
      .id_rt_i       (id_rt),
      .hazard_o      (hazard)
   );

   // A flushed instruction is discarded, so there is nothing to hold upstream.
   assign stall_out   = hazard & ~flush & ~reset;
   assign load_bubble = flush | hazard;

   always_comb begin
      ctrl_d    = CTRL_BUBBLE;
      valid_d   = 1'b0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      bubble_d  = bubble_q;
      if (load_bubble) begin
         if (id_valid && bubble_q != '1) bubble_d = bubble_q + CNT_W'(1);
      end else begin
         ctrl_d    = '{alu_op: id_alu_op, funct: id_funct, reg_write: id_reg_write,
                       mem_read: id_mem_read, mem_write: id_mem_write,
                       mem_to_reg: id_mem_to_reg, alu_src: id_alu_src,
                       reg_dst: id_reg_dst};
         valid_d   = id_valid;
         rs_d      = id_rs;
         rt_d      = id_rt;
         rd_d      = id_rd;
         rs_data_d = id_rs_data;
         rt_data_d = id_rt_data;
         imm_d     = id_imm;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q    <= CTRL_BUBBLE;
         valid_q   <= 1'b0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         bubble_q  <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         valid_q   <= valid_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         bubble_q  <= bubble_d;
      end
   end

   assign ex_valid      = valid_q;
   assign ex_alu_op     = ctrl_q.alu_op;
   assign ex_funct      = ctrl_q.funct;
   assign ex_reg_write  = ctrl_q.reg_write;
   assign ex_mem_read   = ctrl_q.mem_read;
   assign ex_mem_write  = ctrl_q.mem_write;
   assign ex_mem_to_reg = ctrl_q.mem_to_reg;
   assign ex_alu_src    = ctrl_q.alu_src;
   assign ex_reg_dst    = ctrl_q.reg_dst;
   assign ex_rs         = rs_q;
   assign ex_rt         = rt_q;
   assign ex_rd         = rd_q;
   assign ex_rs_data    = rs_data_q;
   assign ex_rt_data    = rt_data_q;
   assign ex_imm        = imm_q;
   assign bubble_count  = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed + random bench for id_ex_stage against a cycle-level reference model;
// a second instance with a 2-bit counter exercises saturation.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset, flush, id_valid;
   logic [2:0]  id_alu_op;
   logic [5:0]  id_funct;
   logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rs_data, id_rt_data, id_imm;

   logic        stall_out, ex_valid;
   logic [2:0]  ex_alu_op;
   logic [5:0]  ex_funct;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
   logic [15:0] bubble_count;

   logic        s_stall, s_valid;
   logic [2:0]  s_alu_op;
   logic [5:0]  s_funct;
   logic        s_rw, s_mr, s_mw, s_m2r, s_src, s_dst;
   logic [4:0]  s_rs, s_rt, s_rd;
   logic [31:0] s_rsd, s_rtd, s_imm;
   logic [1:0]  s_count;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk, .reset, .flush, .id_valid, .id_alu_op, .id_funct, .id_reg_write,
      .id_mem_read, .id_mem_write, .id_mem_to_reg, .id_alu_src, .id_reg_dst,
      .id_rs, .id_rt, .id_rd, .id_rs_data, .id_rt_data, .id_imm,
      .stall_out, .ex_valid, .ex_alu_op, .ex_funct, .ex_reg_write, .ex_mem_read,
      .ex_mem_write, .ex_mem_to_reg, .ex_alu_src, .ex_reg_dst, .ex_rs, .ex_rt,
      .ex_rd, .ex_rs_data, .ex_rt_data, .ex_imm, .bubble_count
   );

   id_ex_stage #(.CNT_W(2)) dut_sat (
      .clk, .reset, .flush, .id_valid, .id_alu_op, .id_funct, .id_reg_write,
      .id_mem_read, .id_mem_write, .id_mem_to_reg, .id_alu_src, .id_reg_dst,
      .id_rs, .id_rt, .id_rd, .id_rs_data, .id_rt_data, .id_imm,
      .stall_out(s_stall), .ex_valid(s_valid), .ex_alu_op(s_alu_op), .ex_funct(s_funct),
      .ex_reg_write(s_rw), .ex_mem_read(s_mr), .ex_mem_write(s_mw), .ex_mem_to_reg(s_m2r),
      .ex_alu_src(s_src), .ex_reg_dst(s_dst), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
      .ex_rs_data(s_rsd), .ex_rt_data(s_rtd), .ex_imm(s_imm), .bubble_count(s_count)
   );

   // Reference model: what EX should hold, plus an unbounded bubble tally.
   typedef struct packed {
      logic        valid;
      logic [2:0]  alu_op;
      logic [5:0]  funct;
      logic        rw, mr, mw, m2r, src, dst;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rsd, rtd, imm;
   } ex_model_t;

   ex_model_t m = '0;
   int        bubbles = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_nop();
      flush = 0; id_valid = 0; id_alu_op = 0; id_funct = 0; id_reg_write = 0;
      id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0; id_alu_src = 0;
      id_reg_dst = 0; id_rs = 0; id_rt = 0; id_rd = 0;
      id_rs_data = 0; id_rt_data = 0; id_imm = 0;
   endtask

   task automatic set_instr(input logic [2:0] op, input logic [5:0] fn, input logic mr,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] rsd, input logic [31:0] rtd);
      id_valid = 1; id_alu_op = op; id_funct = fn; id_mem_read = mr;
      id_reg_write = 1; id_mem_to_reg = mr; id_alu_src = mr; id_reg_dst = (op == 3'b100);
      id_mem_write = 0; id_rs = rs; id_rt = rt; id_rd = rd;
      id_rs_data = rsd; id_rt_data = rtd; id_imm = 32'hFFFF_FFFC;
   endtask

   // Inputs are already applied; check stall, advance model, clock, check EX.
   task automatic cycle(input string tag);
      bit hz, exp_stall;
      int sat16, sat2;
      #1;
      hz = m.valid && m.mr && id_valid && m.rt != 0 && (m.rt == id_rs || m.rt == id_rt);
      exp_stall = hz && !flush && !reset;
      chk({tag, ".stall"}, 64'(stall_out), 64'(exp_stall));
      chk({tag, ".stall_sat"}, 64'(s_stall), 64'(exp_stall));
      if (reset) begin
         m = '0; bubbles = 0;
      end else if (flush || hz) begin
         m = '0;
         if (id_valid) bubbles++;
      end else begin
         m = '{id_valid, id_alu_op, id_funct, id_reg_write, id_mem_read, id_mem_write,
               id_mem_to_reg, id_alu_src, id_reg_dst, id_rs, id_rt, id_rd,
               id_rs_data, id_rt_data, id_imm};
      end
      @(posedge clk);
      #1;
      sat16 = (bubbles > 65535) ? 65535 : bubbles;
      sat2  = (bubbles > 3) ? 3 : bubbles;
      chk({tag, ".valid"}, 64'(ex_valid), 64'(m.valid));
      chk({tag, ".ctrl"}, 64'({ex_alu_op, ex_funct, ex_reg_write, ex_mem_read, ex_mem_write,
                               ex_mem_to_reg, ex_alu_src, ex_reg_dst}),
          64'({m.alu_op, m.funct, m.rw, m.mr, m.mw, m.m2r, m.src, m.dst}));
      chk({tag, ".regs"}, 64'({ex_rs, ex_rt, ex_rd}), 64'({m.rs, m.rt, m.rd}));
      chk({tag, ".rs_data"}, 64'(ex_rs_data), 64'(m.rsd));
      chk({tag, ".rt_data"}, 64'(ex_rt_data), 64'(m.rtd));
      chk({tag, ".imm"}, 64'(ex_imm), 64'(m.imm));
      chk({tag, ".count"}, 64'(bubble_count), 64'(sat16));
      chk({tag, ".count_sat"}, 64'(s_count), 64'(sat2));
   endtask

   initial begin
      @(negedge clk);
      set_nop();
      // Reset dominates a concurrent flush and valid instruction.
      reset = 1; flush = 1; id_valid = 1;
      cycle("reset0");
      cycle("reset1");
      reset = 0;

      set_nop();
      set_instr(3'b100, 6'b100010, 0, 3, 4, 5, 32'h10, 32'h4);
      cycle("pass");

      // Load-use: lw r8, then add using r8 -> one bubble, then the add.
      set_instr(3'b000, 6'b0, 1, 1, 8, 0, 32'h100, 32'h0);
      cycle("lw");
      set_instr(3'b100, 6'b100000, 0, 8, 9, 10, 32'hAAAA, 32'h5555);
      cycle("lu_bubble");
      cycle("lu_add");

      // A load into r0 never stalls.
      set_instr(3'b000, 6'b0, 1, 2, 0, 0, 32'h200, 32'h0);
      cycle("lw_r0");
      set_instr(3'b100, 6'b100110, 0, 0, 0, 11, 32'h1, 32'h2);
      cycle("r0_dep");

      // Hazard and flush together: one bubble, no stall.
      set_instr(3'b000, 6'b0, 1, 1, 7, 0, 32'h300, 32'h0);
      cycle("lw7");
      set_instr(3'b100, 6'b100000, 0, 6, 7, 12, 32'h3, 32'h4);
      flush = 1;
      cycle("flush_hz");
      flush = 0;

      // Back-to-back dependent loads: one stall per pair.
      set_instr(3'b000, 6'b0, 1, 1, 9, 0, 32'h400, 32'h0);
      cycle("lw9");
      set_instr(3'b000, 6'b0, 1, 9, 13, 0, 32'h500, 32'h0);
      cycle("lw13_stall");
      cycle("lw13_go");

      // Counter saturation on the 2-bit instance.
      for (int i = 0; i < 5; i++) begin
         set_instr(3'b010, 6'b0, 0, 1, 2, 3, 32'h7, 32'h8);
         flush = 1;
         cycle("sat_flush");
      end
      flush = 0;

      // Idle flushes are not counted.
      set_nop();
      flush = 1;
      cycle("idle_flush");

      for (int i = 0; i < 400; i++) begin
         set_nop();
         reset = ($urandom_range(0, 59) == 0);
         flush = ($urandom_range(0, 7) == 0);
         id_valid = ($urandom_range(0, 3) != 0);
         id_alu_op = 3'($urandom_range(0, 4));
         id_funct = 6'($urandom);
         id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
         id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
         id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
         id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
         id_rd = 5'($urandom);
         id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
         cycle("rand");
      end
      reset = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode (ID) and execute (EX) in the 5-stage CPU.
- Captures the decoded control word (3-bit ALUop, funct, memory/writeback controls), operands and register specifiers each cycle.
- Presents them to the EX stage, whose ALU control decoder consumes ex_alu_op and ex_funct.
- Detects load-use hazards, inserts bubbles on hazard or flush, and keeps a saturating bubble counter for performance debug.

Parameters:
DATA_W, 32, operand and immediate width
REG_W, 5, register specifier width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  squash the instruction currently in ID (taken branch or jr)
id_valid  in  1  ID holds a real instruction
id_alu_op  in  3  ALUop from main control
id_funct  in  6  instruction funct field
id_reg_write  in  1  writeback enable
id_mem_read  in  1  load
id_mem_write  in  1  store
id_mem_to_reg  in  1  writeback source select
id_alu_src  in  1  immediate operand select
id_reg_dst  in  1  rd/rt destination select
id_rs  in  REG_W  source register 1
id_rt  in  REG_W  source register 2 / load destination
id_rd  in  REG_W  R-type destination
id_rs_data  in  DATA_W  register file read 1
id_rt_data  in  DATA_W  register file read 2
id_imm  in  DATA_W  sign-extended immediate
stall_out  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  EX holds a real instruction
ex_alu_op, ex_funct, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst  out  3/6/1/1/1/1/1/1  registered copies of the ID controls
ex_rs, ex_rt, ex_rd  out  REG_W  registered specifiers
ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered data
bubble_count  out  CNT_W  number of bubbles inserted since reset, saturating

Behaviour:
- Reset (reset=1 at a rising clk edge) clears every ex_* output and bubble_count to 0.
  - Reset dominates flush and hazard.
  - stall_out is 0 during any cycle with reset=1.
- Hazard (combinational):
  - hazard = ex_valid & ex_mem_read & id_valid & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
- stall_out = hazard & ~flush & ~reset.
  - During a flush, the ID instruction is discarded, so it is not held.
- Per rising edge, when reset=0, priority order:
  1. flush=1: load a bubble.
  2. hazard=1: load a bubble. Upstream holds, so the same ID instruction is re-presented next cycle.
  3. Otherwise: capture all id_* inputs. ex_valid <= id_valid.
- Bubble contents: all ex_* outputs 0.
  - ALUop 000 selects add; reg_write and mem_write are 0, so the bubble is architecturally inert.
- Counting: bubble_count increments on every edge that loads a bubble due to flush or hazard while id_valid=1.
  - Idle cycles with id_valid=0 are not counted.
  - The counter saturates at all-ones and never wraps.
- Latency: exactly one cycle from ID inputs to ex_* outputs. There is no internal buffering beyond one entry.
- A load followed by a dependent instruction yields exactly one bubble.
  - On the next cycle ex_mem_read=0 (bubble), so the hazard clears and the dependent instruction advances.
- Back-to-back loads with a dependency stall once per dependent pair.
- A hazard and a flush in the same cycle count as one bubble.
- An ID instruction whose rs or rt matches ex_rt=0 never stalls.

Decomposition:
- Shared package (cpu_pkg):
  - ALUop encodings: LWSW=000, BEQ=001, ADDI=010, SUBI=011, RTYPE=100.
  - funct codes: ADD=100000, SUB=100010, XOR=100110, JR=001000.
  - DATA_W and REG_W defaults.
- Sub-module load_use_detect (purely combinational): inputs are ex_valid, ex_mem_read, ex_rt, id_valid, id_rs, id_rt; output is hazard.
  - The hazard logic is reused by the later forwarding unit.

Test Plan:
- Reset: hold reset=1 for 2 cycles with flush=1 and id_valid=1 -> all ex_* = 0, bubble_count=0, stall_out=0.
- Pass-through: id_valid=1, id_alu_op=100, id_funct=100010, rs=3, rt=4, rd=5, rs_data=0x10, rt_data=0x4 -> next cycle ex_* match the inputs, ex_valid=1, stall_out=0.
- Load-use: cycle 0 lw with rt=8 (mem_read=1); cycle 1 add with rs=8 -> stall_out=1 in cycle 1.
  - Cycle 2: EX holds a bubble (ex_valid=0, ex_alu_op=000), bubble_count=1.
  - Cycle 3: EX holds the add.
- Zero register: lw with rt=0, then an instruction with rs=0 -> stall_out=0, no bubble.
- Flush vs. hazard: flush=1 in the same cycle as a load-use hazard -> stall_out=0, one bubble, bubble_count increments by exactly 1.
- Saturation: preload the counter near max (CNT_W=2 build), force 5 flushes with id_valid=1 -> bubble_count sticks at 3.
